// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin arbiter sharing one logical shift unit
module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter bit RR_EN   = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_lr,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [DATA_W-1:0]  req0_src,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_lr,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [DATA_W-1:0]  req1_src,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               busy_o
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t              state;
    logic                owner;
    logic                last_grant;
    logic                drain;
    logic                window;
    logic                sel;
    logic                grant;
    logic                op_lr;
    logic [SHAMT_W-1:0]  op_shamt;
    logic [DATA_W-1:0]   op_src;
    logic [DATA_W-1:0]   shifted;

    always_comb begin
        drain  = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
        // Ready is gated by reset so nothing is accepted while rst_n is low.
        window = rst_n && ((state == IDLE) || drain);
        if (req0_valid && req1_valid)
            sel = RR_EN ? ~last_grant : 1'b0;
        else
            sel = req1_valid;
        grant      = window && (req0_valid || req1_valid);
        req0_ready = grant && !sel;
        req1_ready = grant && sel;
        op_lr      = sel ? req1_lr    : req0_lr;
        op_shamt   = sel ? req1_shamt : req0_shamt;
        op_src     = sel ? req1_src   : req0_src;
        shifted    = op_lr ? (op_src >> op_shamt) : (op_src << op_shamt);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_result <= '0;
        end else if (grant) begin
            state      <= RESP;
            owner      <= sel;
            last_grant <= sel;
            rsp_result <= shifted;
        end else if (drain) begin
            state      <= IDLE;
        end
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy_o     = (state == RESP);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter
module tb_shift_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_lr, req1_valid, req1_lr;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [31:0] req0_src, req1_src;
    logic        rsp0_ready, rsp1_ready;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy_o;
    logic [31:0] rsp_result;
    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
    logic [31:0] fp_rsp_result;

    typedef struct packed {
        logic        own;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk_i = ~clk_i;

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .RR_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lr(req0_lr),
        .req0_shamt(req0_shamt), .req0_src(req0_src),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lr(req1_lr),
        .req1_shamt(req1_shamt), .req1_src(req1_src),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .busy_o(busy_o)
    );

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk_i), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_lr(req0_lr),
        .req0_shamt(req0_shamt), .req0_src(req0_src),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_lr(req1_lr),
        .req1_shamt(req1_shamt), .req1_src(req1_src),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(fp_rsp_result), .busy_o(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic lr, input logic [4:0] sh,
                                              input logic [31:0] src);
        logic [31:0] r;
        r = src;
        for (int i = 0; i < int'(sh); i++)
            r = lr ? {1'b0, r[31:1]} : {r[30:0], 1'b0};
        return r;
    endfunction

    // Drive one cycle of stimulus at the falling edge, check readies, queue expected results.
    task automatic cyc(input logic v0, input logic lr0, input logic [4:0] sh0, input logic [31:0] s0,
                       input logic v1, input logic lr1, input logic [4:0] sh1, input logic [31:0] s1,
                       input logic r0, input logic r1, input logic e0, input logic e1,
                       input logic [31:0] x0, input logic [31:0] x1);
        @(negedge clk_i);
        req0_valid = v0; req0_lr = lr0; req0_shamt = sh0; req0_src = s0;
        req1_valid = v1; req1_lr = lr1; req1_shamt = sh1; req1_src = s1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        if (e0) exp_q.push_back('{own: 1'b0, res: x0});
        if (e1) exp_q.push_back('{own: 1'b1, res: x1});
    endtask

    task automatic idle(input logic r0, input logic r1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        req0_valid = 0; req1_valid = 0;
        #2 rst_n = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Monitor: pops on every response handshake, plus one-hot and grant-window properties.
    always @(negedge clk_i) begin
        #3;
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid) begin
                compared++; mismatched++;
                $display("FAIL rsp_onehot: both rsp valids high");
            end
            if (req0_ready || req1_ready) begin
                compared++;
                if ((req0_ready && req1_ready) ||
                    (req0_ready && !req0_valid) || (req1_ready && !req1_valid) ||
                    !((!rsp0_valid && !rsp1_valid) || (rsp0_valid && rsp0_ready) ||
                      (rsp1_valid && rsp1_ready))) begin
                    mismatched++;
                    $display("FAIL grant_window: rdy0=%0b rdy1=%0b outside legal window", req0_ready, req1_ready);
                end
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL rsp_unexpected: got result 0x%08h expected none", rsp_result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_owner", {31'd0, rsp1_valid}, {31'd0, e.own});
                    chk("rsp_result", rsp_result, e.res);
                end
            end
        end
    end

    initial begin
        logic        pend0, pend1, ol0, ol1, rr0, rr1;
        logic [4:0]  os0, os1;
        logic [31:0] oc0, oc1;
        logic        bst, bown, blast, drain, win, gsel, g;

        rst_n = 1'b0;
        req0_valid = 1; req0_lr = 0; req0_shamt = 0; req0_src = 0;
        req1_valid = 1; req1_lr = 0; req1_shamt = 0; req1_src = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk_i);
        rst_n = 1'b1;

        // 1: sll 1 by 4
        cyc(1, 0, 4, 32'h0000_0001, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0000_0010, 0);
        idle(1, 1);
        // 2: srl with no sign fill, then shamt 0 back-to-back
        cyc(0, 0, 0, 0, 1, 1, 31, 32'h8000_0000, 1, 1, 0, 1, 0, 32'h0000_0001);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 1, 1, 0, 1, 0, 32'hDEAD_BEEF);
        idle(1, 1);
        // 3: both valid, alternation vs fixed priority
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 32'h3, 1, 1, 2, 32'h100, 1, 1, (i % 2) == 0, (i % 2) == 1,
                32'h6, 32'h40);
            chk("fp_req0_ready", {31'd0, fp_req0_ready}, 1);
            chk("fp_req1_ready", {31'd0, fp_req1_ready}, 0);
        end
        idle(1, 1);
        // 4: stalled response blocks req1
        cyc(1, 0, 8, 32'h1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 1, 4, 32'hF0, 0, 1, 0, 0, 0, 0);
            chk("stall_rsp0_valid", {31'd0, rsp0_valid}, 1);
            chk("stall_result", rsp_result, 32'h100);
        end
        cyc(0, 0, 0, 0, 1, 1, 4, 32'hF0, 1, 1, 0, 1, 0, 32'hF);
        idle(1, 1);
        // 5: async reset while holding a result
        cyc(1, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2, 0);
        @(negedge clk_i);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("pre_rst_busy", {31'd0, busy_o}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rsp0_valid", {31'd0, rsp0_valid}, 0);
        chk("async_busy", {31'd0, busy_o}, 0);
        chk("async_result", rsp_result, 0);
        exp_q.delete();
        @(negedge clk_i);
        rst_n = 1'b1;
        cyc(1, 0, 3, 32'h11, 1, 1, 1, 32'h10, 1, 1, 1, 0, 32'h88, 32'h8);
        cyc(1, 0, 3, 32'h11, 1, 1, 1, 32'h10, 1, 1, 0, 1, 32'h88, 32'h8);
        idle(1, 1);

        // 6: random traffic against an independent reference
        do_reset();
        pend0 = 0; pend1 = 0; bst = 0; bown = 0; blast = 1;
        ol0 = 0; ol1 = 0; os0 = 0; os1 = 0; oc0 = 0; oc1 = 0;
        for (int n = 0; n < 300; n++) begin
            if (pend0 && ($urandom % 16 == 0)) pend0 = 0;
            if (pend1 && ($urandom % 16 == 0)) pend1 = 0;
            if (!pend0 && ($urandom % 2 == 1)) begin
                pend0 = 1; ol0 = 1'($urandom); os0 = 5'($urandom); oc0 = $urandom;
            end
            if (!pend1 && ($urandom % 2 == 1)) begin
                pend1 = 1; ol1 = 1'($urandom); os1 = 5'($urandom); oc1 = $urandom;
            end
            rr0 = ($urandom % 4) != 0;
            rr1 = ($urandom % 4) != 0;
            drain = bst && (bown ? rr1 : rr0);
            win   = !bst || drain;
            gsel  = (pend0 && pend1) ? ~blast : pend1;
            g     = win && (pend0 || pend1);
            cyc(pend0, ol0, os0, oc0, pend1, ol1, os1, oc1, rr0, rr1, g && !gsel, g && gsel,
                ref_shift(ol0, os0, oc0), ref_shift(ol1, os1, oc1));
            if (g) begin
                if (gsel) pend1 = 0; else pend0 = 0;
                bown = gsel; blast = gsel; bst = 1;
            end else if (drain) begin
                bst = 0;
            end
        end
        idle(1, 1);
        idle(1, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
